// File: rtl/dffrf_pkg.sv
// rtl/dffrf_pkg.sv - shared constants and types for the DFF register file
package dffrf_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 32;
  localparam int ADDR_W    = 5;

  typedef logic [WIDTH_DEF-1:0] word_t;
  typedef logic [ADDR_W-1:0]    addr_t;

endpackage

// File: rtl/dffrf_word.sv
// rtl/dffrf_word.sv - one storage word with async active-low clear and load enable
module dffrf_word #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // An unknown load falls through to hold, so a corrupt WE never changes storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dffrf_2r1w_32x32.sv
// rtl/dffrf_2r1w_32x32.sv - flop-based 2-read 1-write register file
module dffrf_2r1w_32x32
  import dffrf_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter bit R0_ZERO = 1'b0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  addr_t            RA,
  output logic [WIDTH-1:0] DA,
  input  addr_t            RB,
  output logic [WIDTH-1:0] DB,
  input  addr_t            RW,
  input  logic             WE,
  input  logic [WIDTH-1:0] DW
);

  logic [DEPTH-1:0] wr_dec;
  logic [DEPTH-1:0] wr_load;
  logic [WIDTH-1:0] mem [DEPTH];

  always_comb begin
    wr_dec     = '0;
    wr_dec[RW] = 1'b1;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    // With R0_ZERO the word 0 flops never load and stay at their reset value.
    assign wr_load[i] = wr_dec[i] & WE & ~(R0_ZERO && (i == 0));

    dffrf_word #(
      .WIDTH (WIDTH)
    ) u_word (
      .clk   (CLK),
      .rst_n (RST_N),
      .load  (wr_load[i]),
      .d     (DW),
      .q     (mem[i])
    );
  end

  // No write bypass: reads see storage only, so a pending write shows after the edge.
  always_comb begin
    DA = mem[RA];
    if (R0_ZERO && (RA == '0)) begin
      DA = '0;
    end
  end

  always_comb begin
    DB = mem[RB];
    if (R0_ZERO && (RB == '0)) begin
      DB = '0;
    end
  end

endmodule

// File: tb/tb_dffrf_2r1w_32x32.sv
// tb/tb_dffrf_2r1w_32x32.sv - self-checking bench for the 2R1W register file
module tb_dffrf_2r1w_32x32;
  import dffrf_pkg::*;

  logic  clk;
  logic  rst_n;
  addr_t ra;
  addr_t rb;
  addr_t rw;
  logic  we;
  word_t dw;
  word_t da0, db0, da1, db1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    addr_t ra;
    addr_t rb;
    word_t exp_a;
    word_t exp_b;
  } rd_vec_t;

  rd_vec_t vecs [4];
  rd_vec_t exp_q [$];

  dffrf_2r1w_32x32 #(.R0_ZERO(1'b0)) u_dut (
    .CLK(clk), .RST_N(rst_n), .RA(ra), .DA(da0), .RB(rb), .DB(db0),
    .RW(rw), .WE(we), .DW(dw)
  );

  dffrf_2r1w_32x32 #(.R0_ZERO(1'b1)) u_dut_z (
    .CLK(clk), .RST_N(rst_n), .RA(ra), .DA(da1), .RB(rb), .DB(db1),
    .RW(rw), .WE(we), .DW(dw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input word_t act, input word_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Expected values are queued when the addresses are driven and popped once outputs settle.
  task automatic read_check(input string name, input addr_t a, input addr_t b,
                            input word_t ea, input word_t eb);
    rd_vec_t v;
    ra = a;
    rb = b;
    v.ra = a; v.rb = b; v.exp_a = ea; v.exp_b = eb;
    exp_q.push_back(v);
    #1;
    v = exp_q.pop_front();
    cmp($sformatf("%s DA[%0d]", name, v.ra), da0, v.exp_a);
    cmp($sformatf("%s DB[%0d]", name, v.rb), db0, v.exp_b);
  endtask

  task automatic do_write(input addr_t a, input word_t d);
    @(negedge clk);
    we = 1'b1;
    rw = a;
    dw = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  initial begin
    vecs[0] = '{ra: 5'd5, rb: 5'd5, exp_a: 32'hDEADBEEF, exp_b: 32'hDEADBEEF};
    vecs[1] = '{ra: 5'd4, rb: 5'd5, exp_a: 32'h00000000, exp_b: 32'hDEADBEEF};
    vecs[2] = '{ra: 5'd5, rb: 5'd4, exp_a: 32'hDEADBEEF, exp_b: 32'h00000000};
    vecs[3] = '{ra: 5'd4, rb: 5'd4, exp_a: 32'h00000000, exp_b: 32'h00000000};

    rst_n = 1'b0;
    we    = 1'b0;
    ra    = '0;
    rb    = 5'd31;
    rw    = '0;
    dw    = '0;

    #3;
    read_check("reset_state", 5'd0, 5'd31, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async clear: preload all ones, then drop reset between edges.
    for (int i = 0; i < 32; i++) do_write(addr_t'(i), 32'hFFFFFFFF);
    read_check("preload", 5'd1, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read_check("async_clear", addr_t'(i), addr_t'(31 - i), 32'h0, 32'h0);
      cmp($sformatf("async_clear_z DA[%0d]", i), da1, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    do_write(5'd5, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++)
      read_check($sformatf("basic_vec%0d", i), vecs[i].ra, vecs[i].rb,
                 vecs[i].exp_a, vecs[i].exp_b);

    for (int i = 0; i < 32; i++) do_write(addr_t'(i), 32'h01010101 * i);
    @(negedge clk);
    for (int i = 0; i < 32; i++)
      read_check("dual_sweep", addr_t'(i), addr_t'(31 - i),
                 32'h01010101 * i, 32'h01010101 * (31 - i));

    // Pending write must not bypass to the read port.
    do_write(5'd7, 32'h12345678);
    @(negedge clk);
    ra = 5'd7;
    we = 1'b1;
    rw = 5'd7;
    dw = 32'hCAFEF00D;
    #1;
    cmp("no_bypass_before", da0, 32'h12345678);
    @(posedge clk);
    #1;
    cmp("no_bypass_after", da0, 32'hCAFEF00D);
    we = 1'b0;
    dw = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    cmp("we_low_hold", da0, 32'hCAFEF00D);

    // All three addresses equal in one cycle.
    @(negedge clk);
    ra = 5'd3; rb = 5'd3; rw = 5'd3; we = 1'b1; dw = 32'h0BADF00D;
    #1;
    cmp("same_addr_old_a", da0, 32'h03030303);
    cmp("same_addr_old_b", db0, 32'h03030303);
    @(posedge clk);
    #1;
    we = 1'b0;
    cmp("same_addr_new_a", da0, 32'h0BADF00D);
    cmp("same_addr_new_b", db0, 32'h0BADF00D);

    do_write(5'd0, 32'hA5A5A5A5);
    do_write(5'd31, 32'h5A5A5A5A);
    @(negedge clk);
    read_check("boundary", 5'd0, 5'd31, 32'hA5A5A5A5, 32'h5A5A5A5A);
    cmp("r0_zero DA[0]", da1, 32'h00000000);
    cmp("r0_zero DB[31]", db1, 32'h5A5A5A5A);

    // Reset held across a write edge blocks the write.
    do_write(5'd9, 32'h22222222);
    read_check("pre_reset_write", 5'd9, 5'd9, 32'h22222222, 32'h22222222);
    @(negedge clk);
    we = 1'b1; rw = 5'd9; dw = 32'h11111111; rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    we = 1'b0;
    read_check("reset_during_write", 5'd9, 5'd31, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dffrf_2r1w_32x32.md
Name: dffrf_2r1w_32x32

Overview:
- Flip-flop-based register file: 32 words x 32 bits, two asynchronous read ports (A, B) and one synchronous write port (W).
- Serves as the synthesizable DFF storage backend behind the 2R1W 32x32 regfile wrapper.
- The wrapper decodes predecoded address lines into binary addresses and a write enable.
- This block only stores and muxes data.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 32, number of words; the address width is log2(DEPTH) = 5.
- R0_ZERO, 0, when 1 word 0 always reads 0 and ignores writes; when 0 word 0 is ordinary storage.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset; clears all storage.
- RA  input  5  read port A address.
- DA  output  32  read port A data.
- RB  input  5  read port B address.
- DB  output  32  read port B data.
- RW  input  5  write address.
- WE  input  1  write enable, active high.
- DW  input  32  write data.

Behaviour:
- Storage: 32 words of 32 flops each. There is no other state.
- Reset:
  - RST_N low clears every word to 0 immediately, without waiting for CLK.
  - While RST_N is low, writes are blocked.
  - DA and DB read 0 for any address while reset is held, because all words are 0.
  - Reset deasserts asynchronously. The first write can occur on the first CLK rising edge with RST_N high.
- Write: on a CLK rising edge with RST_N=1 and WE=1, mem[RW] <= DW. With WE=0, no word changes.
- Write exceptions:
  - If R0_ZERO=1 and RW=0, the write is dropped.
  - An X or Z on WE must not corrupt storage; treat it as no write.
- Reads are purely combinational:
  - DA = mem[RA] and DB = mem[RB], with 0 cycles latency from an address change.
  - If R0_ZERO=1, address 0 returns 0.
- No write-to-read bypass:
  - In the cycle a write to address X is pending, a read of X returns the old value.
  - The new value is visible right after the rising edge (same-edge update, settled within the cycle).
- RA, RB and RW may all be equal in the same cycle. Both read ports then return the same old value, and the write still takes effect.
- Bit order: DA[i], DB[i] and DW[i] map to the same stored bit i. There is no reordering.
- There is no read enable. The outputs always reflect the addressed word.

Decomposition:
- Shared package dffrf_pkg holds:
  - constants WIDTH_DEF=32, DEPTH_DEF=32, ADDR_W=5;
  - typedef word_t (logic [WIDTH-1:0]);
  - typedef addr_t (logic [ADDR_W-1:0]).
- One natural sub-module, dffrf_word:
  - one WIDTH-bit register with async active-low clear;
  - load enable driven by the one-hot write-address decode ANDed with WE.
- The top level instantiates DEPTH copies of dffrf_word, a 5-to-32 write decoder, and two 32:1 read muxes.

Test Plan:
- Reset clears: preload words 0..31 with 0xFFFFFFFF, then assert RST_N=0 mid-cycle with no clock edge -> DA and DB read 0x00000000 for all 32 addresses immediately.
- Basic write/read: WE=1, RW=5, DW=0xDEADBEEF for one edge -> RA=5 gives DA=0xDEADBEEF; RB=5 gives DB=0xDEADBEEF; RA=4 gives 0.
- Dual read, distinct addresses:
  - Stimulus: write mem[i]=0x01010101*i for i=0..31, then sweep RA=i and RB=31-i.
  - Response: DA=0x01010101*i and DB=0x01010101*(31-i) combinationally, with no clock.
- No bypass and write-disable:
  - Stimulus: mem[7]=0x12345678; set RA=7, WE=1, RW=7, DW=0xCAFEF00D.
  - Before the edge: DA=0x12345678. After the edge: DA=0xCAFEF00D.
  - Then hold WE=0 with DW=0x0 for 3 edges -> DA stays 0xCAFEF00D.
- Boundary addresses and R0_ZERO:
  - R0_ZERO=0: write 0xA5A5A5A5 to address 0 and 0x5A5A5A5A to address 31 -> both read back exactly.
  - R0_ZERO=1: the same write to address 0 -> DA(RA=0)=0x00000000.
- Reset during write: WE=1, RW=9, DW=0x11111111 with RST_N=0 across the edge -> mem[9] reads 0 after RST_N returns high.
